// File: rtl/msrv_32_pipe_ctrl_if.sv
// Control bundle between the msrv32 datapath (master) and the pipeline sequencing controller (slave).
// Inputs carry hazard/event requests; outputs carry stage-2 register and PC controls.
interface msrv_32_pipe_ctrl_if;
  logic       branch_taken_in;
  logic       mret_in;
  logic       trap_req_in;
  logic       dmem_req_in;
  logic       dmem_ready_in;
  logic       imem_ready_in;
  logic       reg2_en_out;
  logic       reg2_flush_out;
  logic       pc_en_out;
  logic [1:0] pc_sel_out;
  logic       trap_taken_out;
  logic       bus_err_out;
  logic [1:0] state_out;

  modport master (
    output branch_taken_in, mret_in, trap_req_in, dmem_req_in, dmem_ready_in, imem_ready_in,
    input  reg2_en_out, reg2_flush_out, pc_en_out, pc_sel_out, trap_taken_out, bus_err_out, state_out
  );

  modport slave (
    input  branch_taken_in, mret_in, trap_req_in, dmem_req_in, dmem_ready_in, imem_ready_in,
    output reg2_en_out, reg2_flush_out, pc_en_out, pc_sel_out, trap_taken_out, bus_err_out, state_out
  );
endinterface

// File: rtl/msrv_32_pipe_ctrl.sv
// msrv32 pipeline sequencer: fixed-priority redirect/trap/stall resolution with a data-bus watchdog.
// Outputs are combinational from state and inputs; MSRV32_PIPE_PERF_CNT_EN adds stall/flush counters.
module msrv_32_pipe_ctrl #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                 ms_risc32_mp_clk_in,
  input  logic                 ms_risc32_mp_rst_in,
  msrv_32_pipe_ctrl_if.slave   bus
`ifdef MSRV32_PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt_out,
  output logic [CNT_W-1:0]     flush_cnt_out
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10,
    TRAP     = 2'b11
  } state_e;

  localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);
  localparam logic [7:0] TMO_M1  = 8'(MEM_TIMEOUT - 1);
  localparam logic [1:0] FL_LOAD = 2'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       bus_err_q, bus_err_d;

  logic       reg2_en, reg2_flush, pc_en, trap_taken, bus_err;
  logic [1:0] pc_sel, state_dbg;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    bus_err_d   = bus_err_q;
    reg2_en     = 1'b0;
    reg2_flush  = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 2'b00;
    trap_taken  = 1'b0;
    bus_err     = 1'b0;
    state_dbg   = state_q;

    unique case (state_q)
      RUN: begin
        if (bus.trap_req_in) begin
          state_d = TRAP;
        end else if (bus.mret_in || bus.branch_taken_in) begin
          reg2_en     = 1'b1;
          reg2_flush  = 1'b1;
          pc_en       = 1'b1;
          pc_sel      = bus.mret_in ? 2'b11 : 2'b01;
          state_d     = FLUSH;
          flush_cnt_d = FL_LOAD;
        end else if (bus.dmem_req_in && !bus.dmem_ready_in) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd0;
        end else if (!bus.imem_ready_in) begin
          reg2_en    = 1'b1;
          reg2_flush = 1'b1;
        end else begin
          reg2_en = 1'b1;
          pc_en   = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Saturating count: the watchdog never wraps back into a long wait.
        if (wait_cnt_q != TMO) wait_cnt_d = wait_cnt_q + 8'd1;
        if (bus.dmem_ready_in) begin
          reg2_en = 1'b1;
          pc_en   = 1'b1;
          state_d = RUN;
        end else if (wait_cnt_q >= TMO_M1) begin
          state_d   = TRAP;
          bus_err_d = 1'b1;
        end
      end
      FLUSH: begin
        reg2_en    = 1'b1;
        reg2_flush = 1'b1;
        pc_en      = bus.imem_ready_in;
        if (bus.trap_req_in) begin
          state_d = TRAP;
        end else if (flush_cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      TRAP: begin
        reg2_en     = 1'b1;
        reg2_flush  = 1'b1;
        pc_en       = 1'b1;
        pc_sel      = 2'b10;
        trap_taken  = 1'b1;
        bus_err     = bus_err_q;
        bus_err_d   = 1'b0;
        state_d     = FLUSH;
        flush_cnt_d = FL_LOAD;
      end
      default: state_d = RUN;
    endcase

    if (ms_risc32_mp_rst_in) begin
      reg2_en    = 1'b0;
      reg2_flush = 1'b1;
      pc_en      = 1'b0;
      pc_sel     = 2'b00;
      trap_taken = 1'b0;
      bus_err    = 1'b0;
      state_dbg  = RUN;
    end
  end

  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      flush_cnt_q <= 2'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.reg2_en_out    = reg2_en;
  assign bus.reg2_flush_out = reg2_flush;
  assign bus.pc_en_out      = pc_en;
  assign bus.pc_sel_out     = pc_sel;
  assign bus.trap_taken_out = trap_taken;
  assign bus.bus_err_out    = bus_err;
  assign bus.state_out      = state_dbg;

`ifdef MSRV32_PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_perf_q, flush_cnt_perf_d;
  logic             stall_inc, flush_inc;

  always_comb begin
    stall_inc        = !reg2_en || (!pc_en && (state_q == RUN));
    flush_inc        = reg2_flush && !ms_risc32_mp_rst_in;
    stall_cnt_d      = stall_cnt_q;
    flush_cnt_perf_d = flush_cnt_perf_q;
    if (stall_inc && !(&stall_cnt_q))      stall_cnt_d      = stall_cnt_q + 1'b1;
    if (flush_inc && !(&flush_cnt_perf_q)) flush_cnt_perf_d = flush_cnt_perf_q + 1'b1;
  end

  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      stall_cnt_q      <= '0;
      flush_cnt_perf_q <= '0;
    end else begin
      stall_cnt_q      <= stall_cnt_d;
      flush_cnt_perf_q <= flush_cnt_perf_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
  assign flush_cnt_out = flush_cnt_perf_q;
`endif

endmodule

// File: tb/tb_msrv_32_pipe_ctrl.sv
// Scoreboard bench for msrv_32_pipe_ctrl (MEM_TIMEOUT=8, FLUSH_CYCLES=1): stimulus pushes expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_msrv_32_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  msrv_32_pipe_ctrl_if bus_if ();

`ifdef MSRV32_PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  msrv_32_pipe_ctrl #(
    .MEM_TIMEOUT  (8),
    .FLUSH_CYCLES (1),
    .CNT_W        (32)
  ) dut (
    .ms_risc32_mp_clk_in (clk),
    .ms_risc32_mp_rst_in (rst),
    .bus                 (bus_if.slave)
`ifdef MSRV32_PIPE_PERF_CNT_EN
    ,
    .stall_cnt_out       (stall_cnt),
    .flush_cnt_out       (flush_cnt)
`endif
  );

  // Expected vector: {reg2_en, reg2_flush, pc_en, pc_sel[1:0], trap_taken, bus_err, state[1:0]}
  localparam logic [8:0] ALL    = 9'h1FF;
  localparam logic [8:0] NOFLPS = 9'h14F;
  localparam logic [8:0] NOPS   = 9'h1CF;
  localparam logic [8:0] NOFL   = 9'h17F;

  typedef struct {
    string      nm;
    logic [8:0] e;
    logic [8:0] care;
    int         stall;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [8:0] ex(input bit en, input bit fl, input bit pe, input bit [1:0] ps,
                                    input bit tt, input bit be, input bit [1:0] st);
    return {en, fl, pe, ps, tt, be, st};
  endfunction

  // Input vector: {trap_req, mret, branch_taken, dmem_req, dmem_ready, imem_ready}
  task automatic step(input string nm, input logic r, input logic [5:0] in,
                      input logic [8:0] e, input logic [8:0] care, input int stall = -1);
    exp_t x;
    @(posedge clk);
    #1;
    rst                    = r;
    bus_if.trap_req_in     = in[5];
    bus_if.mret_in         = in[4];
    bus_if.branch_taken_in = in[3];
    bus_if.dmem_req_in     = in[2];
    bus_if.dmem_ready_in   = in[1];
    bus_if.imem_ready_in   = in[0];
    x.nm    = nm;
    x.e     = e;
    x.care  = care;
    x.stall = stall;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t       x;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        x   = sb.pop_front();
        got = {bus_if.reg2_en_out, bus_if.reg2_flush_out, bus_if.pc_en_out, bus_if.pc_sel_out,
               bus_if.trap_taken_out, bus_if.bus_err_out, bus_if.state_out};
        n_chk++;
        if ((got & x.care) == (x.e & x.care)) n_pass++;
        else $display("FAIL %s: got %b required %b (care %b)", x.nm, got, x.e, x.care);
`ifdef MSRV32_PIPE_PERF_CNT_EN
        if (x.stall >= 0) begin
          n_chk++;
          if (stall_cnt == 32'(x.stall)) n_pass++;
          else $display("FAIL %s_stall_cnt: got %0d required %0d", x.nm, stall_cnt, x.stall);
        end
`endif
      end
    end
  end

  initial begin : stim
    bus_if.trap_req_in     = 1'b0;
    bus_if.mret_in         = 1'b0;
    bus_if.branch_taken_in = 1'b0;
    bus_if.dmem_req_in     = 1'b0;
    bus_if.dmem_ready_in   = 1'b0;
    bus_if.imem_ready_in   = 1'b1;

    for (int i = 0; i < 3; i++) step("rst", 1'b1, 6'b000001, ex(0,1,0,2'b00,0,0,2'd0), ALL);
    step("run0",   1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);
    step("run1",   1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);

    // Branch redirect with one bubble
    step("br",     1'b0, 6'b001001, ex(1,1,1,2'b01,0,0,2'd0), ALL);
    step("br_fl",  1'b0, 6'b000001, ex(1,1,1,2'b00,0,0,2'd2), ALL);
    step("br_run", 1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);

    step("imem_st", 1'b0, 6'b000000, ex(1,1,0,2'b00,0,0,2'd0), NOPS);
    step("run2",    1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);

    // Data wait: 5 stalled cycles, trap raised mid-wait is deferred to RUN
    step("dm_req",  1'b0, 6'b000101, ex(0,0,0,2'b00,0,0,2'd0), NOFLPS);
    step("dm_w0",   1'b0, 6'b000001, ex(0,0,0,2'b00,0,0,2'd1), NOFLPS);
    step("dm_w1",   1'b0, 6'b000001, ex(0,0,0,2'b00,0,0,2'd1), NOFLPS);
    step("dm_w2",   1'b0, 6'b100001, ex(0,0,0,2'b00,0,0,2'd1), NOFLPS);
    step("dm_w3",   1'b0, 6'b100001, ex(0,0,0,2'b00,0,0,2'd1), NOFLPS);
    step("dm_rdy",  1'b0, 6'b100011, ex(1,0,1,2'b00,0,0,2'd1), NOFL);
    step("dm_trq",  1'b0, 6'b100001, ex(0,0,0,2'b00,0,0,2'd0), NOFLPS);
    step("dm_trap", 1'b0, 6'b000001, ex(1,1,1,2'b10,1,0,2'd3), ALL);
    step("dm_tfl",  1'b0, 6'b000001, ex(1,1,1,2'b00,0,0,2'd2), ALL);
    step("run3",    1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);

    // Watchdog: 8 wait cycles then bus-error trap
    step("to_req",  1'b0, 6'b000101, ex(0,0,0,2'b00,0,0,2'd0), NOFLPS);
    for (int i = 0; i < 8; i++) step("to_w", 1'b0, 6'b000001, ex(0,0,0,2'b00,0,0,2'd1), NOFLPS);
    step("to_trap", 1'b0, 6'b000001, ex(1,1,1,2'b10,1,1,2'd3), ALL);
    step("to_fl",   1'b0, 6'b000001, ex(1,1,1,2'b00,0,0,2'd2), ALL);
    step("to_run",  1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);

    // trap + mret + branch together: trap wins
    step("all3",      1'b0, 6'b111001, ex(0,0,0,2'b00,0,0,2'd0), NOFLPS);
    step("all3_trap", 1'b0, 6'b000001, ex(1,1,1,2'b10,1,0,2'd3), ALL);
    step("all3_fl",   1'b0, 6'b000001, ex(1,1,1,2'b00,0,0,2'd2), ALL);
    step("run4",      1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);

    // mret; squashed branch/mret ignored in FLUSH, pc_en follows imem_ready
    step("mret",    1'b0, 6'b010001, ex(1,1,1,2'b11,0,0,2'd0), ALL);
    step("mret_fl", 1'b0, 6'b011000, ex(1,1,0,2'b00,0,0,2'd2), ALL);
    step("run5",    1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);

    // Trap request during FLUSH
    step("br2",        1'b0, 6'b001001, ex(1,1,1,2'b01,0,0,2'd0), ALL);
    step("fl_trq",     1'b0, 6'b100001, ex(1,1,1,2'b00,0,0,2'd2), ALL);
    step("fl_trap",    1'b0, 6'b000001, ex(1,1,1,2'b10,1,0,2'd3), ALL);
    step("fl_trap_fl", 1'b0, 6'b000001, ex(1,1,1,2'b00,0,0,2'd2), ALL);
    step("run6",       1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);

    // Reset while in MEM_WAIT, then a fresh wait that must not time out early
    step("rm_req",  1'b0, 6'b000101, ex(0,0,0,2'b00,0,0,2'd0), NOFLPS);
    step("rm_w0",   1'b0, 6'b000001, ex(0,0,0,2'b00,0,0,2'd1), NOFLPS);
    step("rm_rst",  1'b1, 6'b000001, ex(0,1,0,2'b00,0,0,2'd0), ALL);
    step("rm_req2", 1'b0, 6'b000101, ex(0,0,0,2'b00,0,0,2'd0), NOFLPS, 0);
    step("rm_w1",   1'b0, 6'b000001, ex(0,0,0,2'b00,0,0,2'd1), NOFLPS, 1);
    step("rm_w2",   1'b0, 6'b000001, ex(0,0,0,2'b00,0,0,2'd1), NOFLPS, 2);
    for (int i = 0; i < 5; i++) step("rm_w", 1'b0, 6'b000001, ex(0,0,0,2'b00,0,0,2'd1), NOFLPS);
    step("rm_rdy",  1'b0, 6'b000011, ex(1,0,1,2'b00,0,0,2'd1), NOFL);
    step("run7",    1'b0, 6'b000001, ex(1,0,1,2'b00,0,0,2'd0), ALL);

    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d pending entries required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
